// File: rtl/msrv32_split_load_unit.sv
// Load unit: one load per transaction, one or two word-aligned bus reads, merge, extract, extend.
// Optional macro MSRV32_LU_MISALIGN_TRAP_EN turns boundary-crossing loads into a trap response.
module msrv32_split_load_unit #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             ms_riscv32_mp_clk_in,
   input  logic             ms_riscv32_mp_rst_in,
   input  logic             req_valid_in,
   output logic             req_ready_out,
   input  logic [XLEN-1:0]  addr_in,
   input  logic [1:0]       load_size_in,
   input  logic             load_unsigned_in,
   input  logic [TAG_W-1:0] rd_tag_in,
   output logic             dm_req_out,
   output logic [XLEN-1:0]  dm_addr_out,
   input  logic             dm_gnt_in,
   input  logic             dm_rvalid_in,
   input  logic [XLEN-1:0]  ms_riscv32_mp_dmdata_in,
   output logic             lu_valid_out,
   input  logic             lu_ready_in,
   output logic [XLEN-1:0]  lu_output_out,
   output logic [TAG_W-1:0] lu_rd_tag_out,
   output logic             lu_misaligned_out
);

   localparam int BYTES = XLEN / 8;
   localparam int OFS_W = $clog2(BYTES);
   localparam logic [4:0] BYTES_L = 5'(BYTES);

`ifdef MSRV32_LU_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_REQ0, S_WAIT0, S_REQ1, S_WAIT1, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [1:0]       size_q, size_d;
   logic             uns_q, uns_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [XLEN-1:0]  word0_q, word0_d;
   logic [XLEN-1:0]  word1_q, word1_d;
   logic             mis_q, mis_d;

   function automatic logic [4:0] size_of(input logic [1:0] sz);
      logic [4:0] s;
      s = 5'd1 << sz;
      if (s > BYTES_L) s = BYTES_L;
      return s;
   endfunction

   function automatic logic is_split(input logic [OFS_W-1:0] ofs, input logic [1:0] sz);
      return (5'(ofs) + size_of(sz)) > BYTES_L;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      tag_d   = tag_q;
      word0_d = word0_q;
      word1_d = word1_q;
      mis_d   = mis_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_in) begin
               addr_d  = addr_in;
               size_d  = load_size_in;
               uns_d   = load_unsigned_in;
               tag_d   = rd_tag_in;
               word0_d = '0;
               word1_d = '0;
               mis_d   = 1'b0;
               state_d = S_REQ0;
               if (TRAP_EN && is_split(addr_in[OFS_W-1:0], load_size_in)) begin
                  mis_d   = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_REQ0:  if (dm_gnt_in) state_d = S_WAIT0;
         S_WAIT0: begin
            if (dm_rvalid_in) begin
               word0_d = ms_riscv32_mp_dmdata_in;
               state_d = is_split(addr_q[OFS_W-1:0], size_q) ? S_REQ1 : S_RESP;
            end
         end
         S_REQ1:  if (dm_gnt_in) state_d = S_WAIT1;
         S_WAIT1: begin
            if (dm_rvalid_in) begin
               word1_d = ms_riscv32_mp_dmdata_in;
               state_d = S_RESP;
            end
         end
         S_RESP:  if (lu_ready_in) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
      if (ms_riscv32_mp_rst_in) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         tag_q   <= '0;
         word0_q <= '0;
         word1_q <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         tag_q   <= tag_d;
         word0_q <= word0_d;
         word1_q <= word1_d;
         mis_q   <= mis_d;
      end
   end

   logic [XLEN-1:0]  aligned_addr;
   logic [XLEN-1:0]  field_lo;
   logic [XLEN-1:0]  mask;
   logic [4:0]       sz_bytes;
   logic [OFS_W+2:0] msb_idx;
   logic             ext_bit;
   logic [XLEN-1:0]  result;

   assign aligned_addr = {addr_q[XLEN-1:OFS_W], {OFS_W{1'b0}}};

   // Shift the two-word window right by the byte offset, then keep size bytes.
   always_comb begin
      field_lo = XLEN'({word1_q, word0_q} >> {addr_q[OFS_W-1:0], 3'b000});
      sz_bytes = size_of(size_q);
      mask     = '0;
      for (int i = 0; i < BYTES; i++) begin
         mask[8*i +: 8] = (5'(i) < sz_bytes) ? 8'hFF : 8'h00;
      end
      msb_idx  = (OFS_W+3)'({sz_bytes, 3'b000} - 8'd1);
      ext_bit  = ~uns_q & field_lo[msb_idx];
      result   = (field_lo & mask) | (ext_bit ? ~mask : '0);
   end

   assign req_ready_out = (state_q == S_IDLE);
   assign dm_req_out    = (state_q == S_REQ0) || (state_q == S_REQ1);
   assign dm_addr_out   = (state_q == S_REQ0) ? aligned_addr :
                          (state_q == S_REQ1) ? aligned_addr + XLEN'(BYTES) : '0;
   assign lu_valid_out  = (state_q == S_RESP);
   assign lu_output_out = (state_q == S_RESP && !mis_q) ? result : '0;
   assign lu_rd_tag_out = (state_q == S_RESP) ? tag_q : '0;

`ifdef MSRV32_LU_MISALIGN_TRAP_EN
   assign lu_misaligned_out = (state_q == S_RESP) && mis_q;
`else
   assign lu_misaligned_out = 1'b0;
`endif

endmodule

// File: tb/tb_msrv32_split_load_unit.sv
// Directed bench for msrv32_split_load_unit (XLEN=32) with a small bus/memory responder.
module tb_msrv32_split_load_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid_in = 1'b0;
   logic        req_ready_out;
   logic [31:0] addr_in = '0;
   logic [1:0]  load_size_in = '0;
   logic        load_unsigned_in = 1'b0;
   logic [4:0]  rd_tag_in = '0;
   logic        dm_req_out;
   logic [31:0] dm_addr_out;
   logic        dm_gnt_in;
   logic        dm_rvalid_in;
   logic [31:0] dmdata;
   logic        lu_valid_out;
   logic        lu_ready_in = 1'b1;
   logic [31:0] lu_output_out;
   logic [4:0]  lu_rd_tag_out;
   logic        lu_misaligned_out;

   int checks = 0;
   int failures = 0;

   logic        gnt_en = 1'b1;
   logic        inj_rv = 1'b0;
   logic        rv_q = 1'b0;
   logic [31:0] raddr_q = '0;
   logic [31:0] mem_w0 = 32'h11223344;
   logic [31:0] mem_w1 = 32'h55667788;
   logic [31:0] act_q[$];
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   msrv32_split_load_unit #(.XLEN(32), .TAG_W(5)) dut (
      .ms_riscv32_mp_clk_in    (clk),
      .ms_riscv32_mp_rst_in    (rst),
      .req_valid_in            (req_valid_in),
      .req_ready_out           (req_ready_out),
      .addr_in                 (addr_in),
      .load_size_in            (load_size_in),
      .load_unsigned_in        (load_unsigned_in),
      .rd_tag_in               (rd_tag_in),
      .dm_req_out              (dm_req_out),
      .dm_addr_out             (dm_addr_out),
      .dm_gnt_in               (dm_gnt_in),
      .dm_rvalid_in            (dm_rvalid_in),
      .ms_riscv32_mp_dmdata_in (dmdata),
      .lu_valid_out            (lu_valid_out),
      .lu_ready_in             (lu_ready_in),
      .lu_output_out           (lu_output_out),
      .lu_rd_tag_out           (lu_rd_tag_out),
      .lu_misaligned_out       (lu_misaligned_out)
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h0000_0100: return mem_w0;
         32'h0000_0104: return mem_w1;
         32'hFFFF_FFFC: return 32'hAABBCCDD;
         32'h0000_0000: return 32'h01020304;
         default:       return 32'hDEADBEEF;
      endcase
   endfunction

   // Same-cycle grant; read data returns the cycle after the grant.
   assign dm_gnt_in    = dm_req_out & gnt_en;
   assign dm_rvalid_in = rv_q | inj_rv;
   assign dmdata       = mem_rd(raddr_q);

   always @(posedge clk) begin
      rv_q    <= dm_req_out & dm_gnt_in;
      raddr_q <= dm_addr_out;
      if (dm_req_out && dm_gnt_in) act_q.push_back(dm_addr_out);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (!lu_valid_out && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!lu_valid_out) begin
         failures++;
         $display("FAIL timeout: lu_valid_out not seen after %0d cycles", lat);
         lat = -1;
      end
   endtask

   task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [4:0] tg, output logic [31:0] o, output logic [4:0] ot,
                          output logic m, output int lat);
      @(negedge clk);
      act_q.delete();
      req_valid_in = 1'b1;
      addr_in = a;
      load_size_in = sz;
      load_unsigned_in = u;
      rd_tag_in = tg;
      @(posedge clk);
      @(negedge clk);
      req_valid_in = 1'b0;
      wait_valid(lat);
      o  = lu_output_out;
      ot = lu_rd_tag_out;
      m  = lu_misaligned_out;
      @(posedge clk);
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] w1;
      logic [31:0] exp;
      int          lat;
      int          nrd;
      logic [31:0] a0;
      logic [31:0] a1;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] o;
      logic [4:0]  ot;
      logic        m;
      int          lat;
      vec_t        v;
      logic        exp_mis;
      string       nm;

      vecs[0]  = '{32'h100, 2'd2, 1'b0, 32'h55667788, 32'h11223344, 3, 1, 32'h100, 32'h0};
      vecs[1]  = '{32'h103, 2'd0, 1'b0, 32'h55667788, 32'h00000011, 3, 1, 32'h100, 32'h0};
      vecs[2]  = '{32'h107, 2'd0, 1'b0, 32'h55667788, 32'h00000055, 3, 1, 32'h104, 32'h0};
      vecs[3]  = '{32'h107, 2'd0, 1'b0, 32'h80000000, 32'hFFFFFF80, 3, 1, 32'h104, 32'h0};
      vecs[4]  = '{32'h107, 2'd0, 1'b1, 32'h80000000, 32'h00000080, 3, 1, 32'h104, 32'h0};
      vecs[5]  = '{32'h103, 2'd1, 1'b0, 32'h55667788, 32'hFFFF8811, 5, 2, 32'h100, 32'h104};
      vecs[6]  = '{32'h103, 2'd1, 1'b1, 32'h55667788, 32'h00008811, 5, 2, 32'h100, 32'h104};
      vecs[7]  = '{32'h102, 2'd2, 1'b0, 32'h55667788, 32'h77881122, 5, 2, 32'h100, 32'h104};
      vecs[8]  = '{32'h102, 2'd1, 1'b0, 32'h55667788, 32'h00001122, 3, 1, 32'h100, 32'h0};
      vecs[9]  = '{32'h106, 2'd1, 1'b0, 32'h55667788, 32'h00005566, 3, 1, 32'h104, 32'h0};
      vecs[10] = '{32'h100, 2'd3, 1'b0, 32'h55667788, 32'h11223344, 3, 1, 32'h100, 32'h0};
      vecs[11] = '{32'h101, 2'd1, 1'b0, 32'h55667788, 32'h00002233, 3, 1, 32'h100, 32'h0};
      vecs[12] = '{32'h103, 2'd2, 1'b0, 32'h55667788, 32'h66778811, 5, 2, 32'h100, 32'h104};
      vecs[13] = '{32'hFFFFFFFE, 2'd2, 1'b0, 32'h55667788, 32'h0304AABB, 5, 2, 32'hFFFFFFFC, 32'h0};

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req_ready", {31'd0, req_ready_out}, 32'd1);
      chk("rst_dm_req", {31'd0, dm_req_out}, 32'd0);
      chk("rst_lu_valid", {31'd0, lu_valid_out}, 32'd0);
      chk("rst_output", lu_output_out, 32'd0);
      chk("rst_tag", {27'd0, lu_rd_tag_out}, 32'd0);
      chk("rst_mis", {31'd0, lu_misaligned_out}, 32'd0);
      rst = 1'b0;

      // Table-driven loads
      for (int i = 0; i < 14; i++) begin
         v = vecs[i];
         exp_mis = 1'b0;
`ifdef MSRV32_LU_MISALIGN_TRAP_EN
         if (v.nrd == 2) begin
            v.exp = 32'd0;
            v.lat = 1;
            v.nrd = 0;
            exp_mis = 1'b1;
         end
`endif
         mem_w1 = v.w1;
         exp_q.delete();
         if (v.nrd >= 1) exp_q.push_back(v.a0);
         if (v.nrd >= 2) exp_q.push_back(v.a1);
         do_load(v.addr, v.sz, v.uns, 5'(i + 3), o, ot, m, lat);
         nm = $sformatf("v%0d", i);
         chk({nm, "_out"}, o, v.exp);
         chk({nm, "_tag"}, {27'd0, ot}, 32'(i + 3));
         chk({nm, "_mis"}, {31'd0, m}, {31'd0, exp_mis});
         chk({nm, "_lat"}, 32'(lat), 32'(v.lat));
         chk({nm, "_nreads"}, 32'(act_q.size()), 32'(v.nrd));
         while (exp_q.size() > 0 && act_q.size() > 0)
            chk({nm, "_raddr"}, act_q.pop_front(), exp_q.pop_front());
      end
      mem_w1 = 32'h55667788;

      // Consumer stall in RESP with a second request waiting
      @(negedge clk);
      lu_ready_in = 1'b0;
      req_valid_in = 1'b1;
      addr_in = 32'h100; load_size_in = 2'd2; load_unsigned_in = 1'b0; rd_tag_in = 5'd9;
      @(posedge clk);
      @(negedge clk);
      addr_in = 32'h104; rd_tag_in = 5'd10;
      wait_valid(lat);
      for (int k = 0; k < 4; k++) begin
         chk("stall_valid", {31'd0, lu_valid_out}, 32'd1);
         chk("stall_out", lu_output_out, 32'h11223344);
         chk("stall_tag", {27'd0, lu_rd_tag_out}, 32'd9);
         chk("stall_req_ready", {31'd0, req_ready_out}, 32'd0);
         chk("stall_dm_req", {31'd0, dm_req_out}, 32'd0);
         @(negedge clk);
      end
      lu_ready_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("hs_idle_ready", {31'd0, req_ready_out}, 32'd1);
      chk("hs_idle_valid", {31'd0, lu_valid_out}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      req_valid_in = 1'b0;
      chk("next_dm_req", {31'd0, dm_req_out}, 32'd1);
      chk("next_dm_addr", dm_addr_out, 32'h104);
      wait_valid(lat);
      chk("next_out", lu_output_out, 32'h55667788);
      chk("next_tag", {27'd0, lu_rd_tag_out}, 32'd10);
      @(posedge clk);

      // Reset while a read is pending in WAIT0, then a stray rvalid
      @(negedge clk);
      req_valid_in = 1'b1;
      addr_in = 32'h100; load_size_in = 2'd2; rd_tag_in = 5'd7;
      @(posedge clk);
      @(negedge clk);
      req_valid_in = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstw_dm_req", {31'd0, dm_req_out}, 32'd0);
      chk("rstw_valid", {31'd0, lu_valid_out}, 32'd0);
      chk("rstw_ready", {31'd0, req_ready_out}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      inj_rv = 1'b1;
      @(negedge clk);
      inj_rv = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("late_rv_valid", {31'd0, lu_valid_out}, 32'd0);
         chk("late_rv_ready", {31'd0, req_ready_out}, 32'd1);
         @(negedge clk);
      end

      // Reset while requesting: the bus request drops without a clock edge
      gnt_en = 1'b0;
      req_valid_in = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_in = 1'b0;
      chk("req0_dm_req", {31'd0, dm_req_out}, 32'd1);
      rst = 1'b1;
      #1;
      chk("req0_rst_dm_req", {31'd0, dm_req_out}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      gnt_en = 1'b1;

      // Repeat of the first load after the aborted ones
      do_load(32'h100, 2'd2, 1'b0, 5'd7, o, ot, m, lat);
      chk("again_out", o, 32'h11223344);
      chk("again_tag", {27'd0, ot}, 32'd7);
      chk("again_lat", 32'(lat), 32'd3);
      chk("again_nreads", 32'(act_q.size()), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end

endmodule
